// File: rtl/ibuff_rename_pipe_pkg.sv
// Shared configuration for the instruction-buffer-to-rename pipeline register:
// dispatch width, counter width defaults and the rename packet layout.
package ibuff_rename_pipe_pkg;

  localparam int DISPATCH_WIDTH     = 4;
  localparam int SEQ_WIDTH_DEF      = 8;
  localparam int PERF_CNT_WIDTH_DEF = 32;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  ldst;
  } renPkt;

endpackage

// File: rtl/ibuff_rename_pipe_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc_i && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/ibuff_rename_pipe.sv
// Pipeline register between instruction buffer and rename (flush > stall > capture).
// Optional performance counters are enabled with the IBUFF_REN_PERF_EN macro.
module ibuff_rename_pipe
  import ibuff_rename_pipe_pkg::*;
#(
  parameter int SEQ_WIDTH      = SEQ_WIDTH_DEF,
  parameter int PERF_CNT_WIDTH = PERF_CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic                      stall_i,
  input  logic                      instBufferReady_i,
  input  logic [DISPATCH_WIDTH-1:0] dispatchLaneActive_i,
  input  renPkt                     renPacket_i [0:DISPATCH_WIDTH-1],
  output logic                      renameReady_o,
  output renPkt                     renPacket_o [0:DISPATCH_WIDTH-1],
  output logic [SEQ_WIDTH-1:0]      bundleSeq_o
`ifdef IBUFF_REN_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] perfStallCycles_o,
  output logic [PERF_CNT_WIDTH-1:0] perfBundles_o,
  output logic [PERF_CNT_WIDTH-1:0] perfFlushes_o
`endif
);

  logic                 r_ready;
  logic [SEQ_WIDTH-1:0] r_seq;
  renPkt                r_pkt [0:DISPATCH_WIDTH-1];
  logic                 w_capture;

  assign w_capture = ~flush_i & ~stall_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_seq   <= '0;
    end else if (flush_i) begin
      r_ready <= 1'b0;
    end else if (w_capture) begin
      r_ready <= instBufferReady_i;
      if (instBufferReady_i) begin
        r_seq <= r_seq + 1'b1;
      end
    end
  end

  // While stalled the payload is held, but a lane dropped from the active mask
  // loses its valid so a held bundle never keeps an inactive lane alive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        r_pkt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (flush_i) begin
          r_pkt[i].valid <= 1'b0;
        end else if (stall_i) begin
          r_pkt[i].valid <= r_pkt[i].valid & dispatchLaneActive_i[i];
        end else begin
          r_pkt[i]       <= renPacket_i[i];
          r_pkt[i].valid <= renPacket_i[i].valid & instBufferReady_i
                            & dispatchLaneActive_i[i];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_lane_out
      assign renPacket_o[gi] = r_pkt[gi];
    end
  endgenerate

  assign renameReady_o = r_ready;
  assign bundleSeq_o   = r_seq;

`ifdef IBUFF_REN_PERF_EN
  logic w_stall_inc;
  logic w_bundle_inc;

  assign w_stall_inc  = stall_i & r_ready;
  assign w_bundle_inc = w_capture & instBufferReady_i;

  sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc_i(w_stall_inc), .count_o(perfStallCycles_o)
  );
  sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_bundle_cnt (
    .clk(clk), .reset(reset), .inc_i(w_bundle_inc), .count_o(perfBundles_o)
  );
  sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc_i(flush_i), .count_o(perfFlushes_o)
  );
`endif

endmodule

// File: tb/tb_ibuff_rename_pipe.sv
// Bench for ibuff_rename_pipe: directed vector table, corner sequences and a
// randomized run checked against a behavioural model.
module tb_ibuff_rename_pipe;
  import ibuff_rename_pipe_pkg::*;

  localparam int NL = DISPATCH_WIDTH;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_i, stall_i, ibr_i;
  logic [NL-1:0] act_i;
  renPkt         pkt_i [0:NL-1];
  logic          ready_o;
  renPkt         pkt_o [0:NL-1];
  logic [7:0]    seq_o;
`ifdef IBUFF_REN_PERF_EN
  logic [PW-1:0] perf_stall_o, perf_bund_o, perf_flush_o;
`endif

  ibuff_rename_pipe #(.SEQ_WIDTH(8), .PERF_CNT_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .stall_i(stall_i),
    .instBufferReady_i(ibr_i), .dispatchLaneActive_i(act_i),
    .renPacket_i(pkt_i), .renameReady_o(ready_o), .renPacket_o(pkt_o),
    .bundleSeq_o(seq_o)
`ifdef IBUFF_REN_PERF_EN
    , .perfStallCycles_o(perf_stall_o), .perfBundles_o(perf_bund_o),
    .perfFlushes_o(perf_flush_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit    m_ready;
  int    m_seq;
  renPkt m_pkt [0:NL-1];
  int    m_pstall, m_pbund, m_pflush;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << PW) - 1) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_ready = 0; m_seq = 0; m_pstall = 0; m_pbund = 0; m_pflush = 0;
    for (int i = 0; i < NL; i++) m_pkt[i] = '0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 128'(ready_o), 128'(m_ready));
    chk({tag, ".seq"}, 128'(seq_o), 128'(m_seq));
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("%s.valid%0d", tag, i), 128'(pkt_o[i].valid), 128'(m_pkt[i].valid));
      if (m_pkt[i].valid)
        chk($sformatf("%s.pkt%0d", tag, i), 128'(pkt_o[i]), 128'(m_pkt[i]));
    end
`ifdef IBUFF_REN_PERF_EN
    chk({tag, ".pstall"}, 128'(perf_stall_o), 128'(m_pstall));
    chk({tag, ".pbund"}, 128'(perf_bund_o), 128'(m_pbund));
    chk({tag, ".pflush"}, 128'(perf_flush_o), 128'(m_pflush));
`endif
  endtask

  // Drive one cycle, advance the model with the same inputs, settle past the edge.
  task automatic cycle(input bit f, input bit s, input bit r, input logic [NL-1:0] a,
                       input bit rand_valid);
    flush_i = f; stall_i = s; ibr_i = r; act_i = a;
    for (int i = 0; i < NL; i++) begin
      pkt_i[i].valid = rand_valid ? 1'($urandom) : 1'b1;
      pkt_i[i].pc    = $urandom;
      pkt_i[i].inst  = $urandom;
      pkt_i[i].ldst  = 6'($urandom);
    end
    @(posedge clk);
    if (s && m_ready) m_pstall = sat_inc(m_pstall);
    if (f) begin
      m_pflush = sat_inc(m_pflush);
      m_ready  = 0;
      for (int i = 0; i < NL; i++) m_pkt[i].valid = 1'b0;
    end else if (s) begin
      for (int i = 0; i < NL; i++) m_pkt[i].valid = m_pkt[i].valid && a[i];
    end else begin
      m_ready = r;
      for (int i = 0; i < NL; i++) begin
        m_pkt[i] = pkt_i[i];
        m_pkt[i].valid = pkt_i[i].valid && r && a[i];
      end
      if (r) begin
        m_seq  = (m_seq + 1) % 256;
        m_pbund = sat_inc(m_pbund);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit            f, s, r;
    logic [NL-1:0] a;
    bit            e_ready;
    int            e_seq;
    logic [NL-1:0] e_mask;
  } vec_t;

  vec_t vt [0:11];
  logic [NL-1:0] vmask;

  initial begin
    flush_i = 0; stall_i = 0; ibr_i = 0; act_i = '0;
    for (int i = 0; i < NL; i++) pkt_i[i] = '0;
    model_reset();
    do_reset();
    chk("reset.ready", 128'(ready_o), 128'(0));
    chk("reset.seq", 128'(seq_o), 128'(0));
    for (int i = 0; i < NL; i++) chk($sformatf("reset.valid%0d", i), 128'(pkt_o[i].valid), 128'(0));

    //        f  s  r  act    rdy seq mask
    vt[0]  = '{0, 0, 1, 4'hF, 1, 1, 4'hF};
    vt[1]  = '{0, 1, 1, 4'hF, 1, 1, 4'hF};
    vt[2]  = '{0, 1, 0, 4'hF, 1, 1, 4'hF};
    vt[3]  = '{0, 1, 1, 4'hF, 1, 1, 4'hF};
    vt[4]  = '{1, 1, 1, 4'hF, 0, 1, 4'h0};
    vt[5]  = '{0, 0, 1, 4'h3, 1, 2, 4'h3};
    vt[6]  = '{0, 0, 0, 4'hF, 0, 2, 4'h0};
    vt[7]  = '{0, 0, 1, 4'hF, 1, 3, 4'hF};
    vt[8]  = '{1, 0, 1, 4'hF, 0, 3, 4'h0};
    vt[9]  = '{0, 1, 1, 4'hF, 0, 3, 4'h0};
    vt[10] = '{0, 0, 1, 4'h5, 1, 4, 4'h5};
    vt[11] = '{0, 1, 1, 4'h1, 1, 4, 4'h1};
    for (int v = 0; v < 12; v++) begin
      cycle(vt[v].f, vt[v].s, vt[v].r, vt[v].a, 1'b0);
      for (int i = 0; i < NL; i++) vmask[i] = pkt_o[i].valid;
      chk($sformatf("vec%0d.ready", v), 128'(ready_o), 128'(vt[v].e_ready));
      chk($sformatf("vec%0d.seq", v), 128'(seq_o), 128'(vt[v].e_seq));
      chk($sformatf("vec%0d.mask", v), 128'(vmask), 128'(vt[v].e_mask));
      check_model($sformatf("vec%0d", v));
    end

    // Reset asserted mid-stall discards the held bundle immediately.
    cycle(0, 0, 1, 4'hF, 1'b0);
    cycle(0, 1, 1, 4'hF, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst.ready", 128'(ready_o), 128'(0));
    chk("midrst.seq", 128'(seq_o), 128'(0));
    for (int i = 0; i < NL; i++) chk($sformatf("midrst.valid%0d", i), 128'(pkt_o[i].valid), 128'(0));
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(0, 0, 1, 4'hF, 1'b0);
    chk("postrst.seq", 128'(seq_o), 128'(1));
    check_model("postrst");

`ifdef IBUFF_REN_PERF_EN
    // Long stall with a valid held bundle saturates the stall counter.
    for (int k = 0; k < 20; k++) cycle(0, 1, 1, 4'hF, 1'b0);
    chk("perf.stall_sat", 128'(perf_stall_o), 128'(15));
    check_model("perf");
`endif

    // Sequence wrap after 256 captures from reset.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      cycle(0, 0, 1, 4'hF, 1'b1);
      if (k == 254) chk("wrap.seq255", 128'(seq_o), 128'(255));
    end
    chk("wrap.seq0", 128'(seq_o), 128'(0));
    check_model("wrap");

    // Randomized run against the model.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 7), 4'($urandom), 1'b1);
      check_model($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
